// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller.
// Frame opcodes, controller states and ALU function-group codes.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_A,
    LD_B,
    LD_FUN,
    WAIT,
    TX
  } state_e;

  localparam logic [7:0] CMD_FULL  = 8'hCC;
  localparam logic [7:0] CMD_REUSE = 8'hDD;

  localparam logic [1:0] GRP_ARITH = 2'd0;
  localparam logic [1:0] GRP_LOGIC = 2'd1;
  localparam logic [1:0] GRP_CMP   = 2'd2;
  localparam logic [1:0] GRP_SHIFT = 2'd3;

endpackage

// File: rtl/byte_ser.sv
// Result serialiser: holds the captured result and sends it LSB byte first.
// Ports: clk/rst, load+din capture, busy handshake in, data/vld out, done pulse.
module byte_ser #(
  parameter int OP_WIDTH = 16,
  parameter int BYTE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [OP_WIDTH-1:0] din,
  input  logic                busy,
  output logic [BYTE_W-1:0]   data,
  output logic                vld,
  output logic                done
);

  localparam int NB = OP_WIDTH / BYTE_W;
  localparam int IW = $clog2(NB) + 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  logic [OP_WIDTH-1:0] res_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic                accept;

  assign accept  = vld & ~busy;
  assign done    = accept & (idx == LAST);
  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      idx   <= '0;
      vld   <= 1'b0;
      data  <= '0;
    end else if (load) begin
      res_q <= din;
      idx   <= '0;
      vld   <= 1'b1;
      data  <= din[BYTE_W-1:0];
    end else if (accept) begin
      if (idx == LAST) begin
        // Data is left holding the last byte; only vld drops.
        vld <= 1'b0;
        idx <= '0;
      end else begin
        idx  <= idx_nxt;
        data <= res_q[BYTE_W*int'(idx_nxt) +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses CC/DD frames, drives the ALU, returns result.
// Ports: RX byte strobe in, ALU operands/fun out, ALU results+flags in, TX out.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 16,
  parameter int BYTE_W   = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BYTE_W-1:0]   RX_P_DATA,
  input  logic                RX_D_VLD,
  output logic [OP_WIDTH-1:0] ALU_A,
  output logic [OP_WIDTH-1:0] ALU_B,
  output logic [3:0]          ALU_FUN,
  input  logic [OP_WIDTH-1:0] Arith_OUT,
  input  logic [OP_WIDTH:0]   Logic_OUT,
  input  logic [1:0]          CMP_OUT,
  input  logic [OP_WIDTH-1:0] SHIFT_OUT,
  input  logic                Arith_Flag,
  input  logic                Logic_Flag,
  input  logic                CMP_Flag,
  input  logic                SHIFT_Flag,
  output logic [BYTE_W-1:0]   TX_P_DATA,
  output logic                TX_D_VLD,
  input  logic                TX_BUSY,
  output logic                CTRL_BUSY
);

  localparam int NB = OP_WIDTH / BYTE_W;
  localparam int CW = $clog2(NB) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_e              state;
  state_e              state_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                ld_a;
  logic                ld_b;
  logic                ld_fun;
  logic                load;
  logic                done;
  logic                sel_flag;
  logic [OP_WIDTH-1:0] result;
  logic                unused_logic_msb;

  // Logic carry-out bit is not returned to the host.
  assign unused_logic_msb = Logic_OUT[OP_WIDTH];

  always_comb begin
    sel_flag = 1'b0;
    result   = '0;
    unique case (ALU_FUN[3:2])
      GRP_ARITH: begin
        sel_flag = Arith_Flag;
        result   = Arith_OUT;
      end
      GRP_LOGIC: begin
        sel_flag = Logic_Flag;
        result   = Logic_OUT[OP_WIDTH-1:0];
      end
      GRP_CMP: begin
        sel_flag = CMP_Flag;
        result   = {{(OP_WIDTH-2){1'b0}}, CMP_OUT};
      end
      GRP_SHIFT: begin
        sel_flag = SHIFT_Flag;
        result   = SHIFT_OUT;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_fun    = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_FULL)
            state_nxt = LD_A;
          else if (RX_P_DATA == CMD_REUSE)
            state_nxt = LD_FUN;
        end
      end
      LD_A: begin
        if (RX_D_VLD) begin
          ld_a = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = LD_B;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LD_B: begin
        if (RX_D_VLD) begin
          ld_b = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = LD_FUN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LD_FUN: begin
        if (RX_D_VLD) begin
          ld_fun    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (sel_flag) begin
          load      = 1'b1;
          state_nxt = TX;
        end
      end
      TX: begin
        if (done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      CTRL_BUSY <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      CTRL_BUSY <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= '0;
    end else begin
      if (ld_a)
        ALU_A[BYTE_W*int'(cnt) +: BYTE_W] <= RX_P_DATA;
      if (ld_b)
        ALU_B[BYTE_W*int'(cnt) +: BYTE_W] <= RX_P_DATA;
      if (ld_fun)
        ALU_FUN <= RX_P_DATA[3:0];
    end
  end

  byte_ser #(
    .OP_WIDTH(OP_WIDTH),
    .BYTE_W  (BYTE_W)
  ) u_ser (
    .clk (CLK),
    .rst (RST),
    .load(load),
    .din (result),
    .busy(TX_BUSY),
    .data(TX_P_DATA),
    .vld (TX_D_VLD),
    .done(done)
  );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural ALU response model.
// Driver pushes expected TX bytes; a negedge monitor pops and compares.
module tb_alu_cmd_ctrl;
  import alu_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic [15:0] Arith_OUT = '0;
  logic [16:0] Logic_OUT = '0;
  logic [1:0]  CMP_OUT = '0;
  logic [15:0] SHIFT_OUT = '0;
  logic        Arith_Flag = 1'b0;
  logic        Logic_Flag = 1'b0;
  logic        CMP_Flag = 1'b0;
  logic        SHIFT_Flag = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;
  logic        CTRL_BUSY;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  sb_q[$];
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  bit          busy_force = 1'b0;
  bit          busy_rand = 1'b0;
  bit          gaps = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_data = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    TX_BUSY = busy_force | (busy_rand && ($urandom_range(0, 2) == 0));
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps) repeat ($urandom_range(0, 1)) tick();
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic set_flag(input logic [1:0] g, input logic v);
    case (g)
      2'd0: Arith_Flag = v;
      2'd1: Logic_Flag = v;
      2'd2: CMP_Flag = v;
      default: SHIFT_Flag = v;
    endcase
  endtask

  // Result the host should receive for a given function code.
  function automatic logic [15:0] pick(input logic [3:0] fun,
      input logic [15:0] ar, input logic [16:0] lg,
      input logic [1:0] cm, input logic [15:0] sh);
    case (fun / 4)
      0: return ar;
      1: return lg[15:0];
      2: return {14'd0, cm};
      default: return sh;
    endcase
  endfunction

  // Monitor: one compare per accepted byte, plus stall stability.
  always @(negedge CLK) begin
    logic [7:0] e;
    if (stall_prev) begin
      check("tx_stall_vld", TX_D_VLD, 1);
      check("tx_stall_data", TX_P_DATA, stall_data);
    end
    if (TX_D_VLD === 1'b1 && TX_BUSY === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_extra_byte: got %02h expected none", TX_P_DATA);
      end else begin
        e = sb_q.pop_front();
        check("tx_byte", TX_P_DATA, e);
      end
    end
    stall_prev = (TX_D_VLD === 1'b1) && (TX_BUSY === 1'b1);
    stall_data = TX_P_DATA;
  end

  task automatic run_op(input bit full, input logic [15:0] a,
      input logic [15:0] b, input logic [3:0] fun,
      input logic [15:0] ar, input logic [16:0] lg,
      input logic [1:0] cm, input logic [15:0] sh,
      input int lat, input bit distract, input bit hold,
      input bit junk, input bit end_strobe);
    logic [15:0] exp;
    logic [1:0]  g;
    logic [1:0]  og;
    int          cyc;
    bit          seen;
    Arith_OUT = ar;
    Logic_OUT = lg;
    CMP_OUT   = cm;
    SHIFT_OUT = sh;
    g  = fun[3:2];
    og = g + 2'($urandom_range(1, 3));
    exp = pick(fun, ar, lg, cm, sh);
    sb_q.push_back(exp[7:0]);
    sb_q.push_back(exp[15:8]);
    if (full) begin
      m_a = a;
      m_b = b;
      send_byte(CMD_FULL);
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(b[7:0]);
      send_byte(b[15:8]);
    end else begin
      send_byte(CMD_REUSE);
    end
    send_byte({4'($urandom), fun});
    check("alu_a", ALU_A, m_a);
    check("alu_b", ALU_B, m_b);
    check("alu_fun", ALU_FUN, fun);
    check("busy_wait", CTRL_BUSY, 1);
    for (int i = 0; i < lat; i++) begin
      if (distract && i == 0) set_flag(og, 1'b1);
      tick();
      set_flag(og, 1'b0);
      check("no_early_tx", TX_D_VLD, 0);
    end
    tick();
    set_flag(g, 1'b1);
    tick();
    set_flag(g, 1'b0);
    cyc  = 0;
    seen = 1'b0;
    while (!(CTRL_BUSY === 1'b0 && sb_q.size() == 0) && cyc < 200) begin
      if (TX_D_VLD === 1'b1 && !seen) begin
        seen = 1'b1;
        if (hold) begin
          busy_force = 1'b1;
          TX_BUSY    = 1'b1;
          for (int k = 0; k < 5; k++) begin
            if (junk) begin
              RX_P_DATA = (k == 0) ? CMD_FULL : 8'($urandom);
              RX_D_VLD  = 1'b1;
            end
            tick();
          end
          RX_D_VLD   = 1'b0;
          busy_force = 1'b0;
          TX_BUSY    = 1'b0;
        end
        if (end_strobe) begin
          tick();
          RX_P_DATA = CMD_FULL;
          RX_D_VLD  = 1'b1;
          tick();
          RX_D_VLD  = 1'b0;
          check("drop_at_exit", CTRL_BUSY, 0);
          continue;
        end
      end
      tick();
      cyc++;
    end
    if (cyc >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_timeout: busy=%0b queued=%0d expected idle",
               CTRL_BUSY, sb_q.size());
    end
  endtask

  initial begin
    logic [7:0] s;
    RST = 1'b1;
    tick();
    tick();
    check("rst_alu_a", ALU_A, 0);
    check("rst_alu_b", ALU_B, 0);
    check("rst_alu_fun", ALU_FUN, 0);
    check("rst_tx_data", TX_P_DATA, 0);
    check("rst_tx_vld", TX_D_VLD, 0);
    check("rst_busy", CTRL_BUSY, 0);
    RST = 1'b0;
    tick();

    run_op(1, 16'h0005, 16'h0003, 4'h0, 16'h0008, 17'h0, 2'b0, 16'h0,
           0, 0, 0, 0, 0);
    check("idle_after_op", CTRL_BUSY, 0);
    run_op(0, 16'h0, 16'h0, 4'hA, 16'h1111, 17'h1F0F1, 2'b0, 16'h0,
           0, 0, 0, 0, 0);
    run_op(1, 16'h1234, 16'h00FF, 4'h9, 16'hBEEF, 17'h0, 2'b10, 16'h0,
           2, 1, 0, 0, 0);
    run_op(1, 16'hA5A5, 16'h5A5A, 4'hC, 16'h0, 17'h0, 2'b0, 16'hC3D4,
           1, 0, 1, 1, 0);
    send_byte(8'h55);
    check("stray_idle", CTRL_BUSY, 0);
    run_op(0, 16'h0, 16'h0, 4'h4, 16'h0, 17'h0ABCD, 2'b0, 16'h0,
           0, 0, 0, 0, 1);
    run_op(0, 16'h0, 16'h0, 4'h1, 16'h7E81, 17'h0, 2'b0, 16'h0,
           0, 0, 0, 0, 0);

    send_byte(CMD_FULL);
    send_byte(8'h12);
    send_byte(8'h34);
    RST = 1'b1;
    tick();
    check("mid_rst_busy", CTRL_BUSY, 0);
    check("mid_rst_alu_a", ALU_A, 0);
    check("mid_rst_tx_vld", TX_D_VLD, 0);
    check("mid_rst_tx_data", TX_P_DATA, 0);
    RST = 1'b0;
    m_a = '0;
    m_b = '0;
    tick();
    run_op(0, 16'h0, 16'h0, 4'h0, 16'h0042, 17'h0, 2'b0, 16'h0,
           0, 0, 0, 0, 0);

    busy_rand = 1'b1;
    gaps      = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 8'($urandom);
        if (s == CMD_FULL || s == CMD_REUSE) s = 8'h55;
        send_byte(s);
        check("stray_rand", CTRL_BUSY, 0);
      end
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
             16'($urandom), 17'($urandom), 2'($urandom), 16'($urandom),
             $urandom_range(0, 3), 1'($urandom), 0, 0, 0);
    end
    busy_rand = 1'b0;
    repeat (4) tick();
    check("sb_drain", sb_q.size(), 0);
    check("final_idle", CTRL_BUSY, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
